// File: rtl/systolic_setup_controller.sv
// Sequences one operand-streaming pass (clear, stream K_LEN vectors, zero-flush, done) through the
// skew shift-register banks feeding the systolic array. Define STALL_COUNT_EN to add the STALL_CNT output.
module systolic_setup_controller #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned K_WIDTH    = 16
) (
  input  logic               CLK,
  input  logic               ASYNC_RST,
  input  logic               START,
  input  logic [K_WIDTH-1:0] K_LEN,
  input  logic               ABORT,
  input  logic               SRC_VALID,
  output logic               SRC_READY,
  output logic               SR_EN,
  output logic               SR_SYNC_RST,
  output logic               FEED_ZERO,
  output logic               BUSY,
  output logic               DONE
`ifdef STALL_COUNT_EN
  ,
  output logic [K_WIDTH-1:0] STALL_CNT
`endif
);

  localparam int unsigned FLUSH_LEN = 2 * ARRAY_SIZE - 2;
  localparam int unsigned FW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DONE_S
  } state_e;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_reg_q, k_reg_d;
  logic [K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;

  logic ready_q, ready_d;
  logic clear_q, clear_d;
  logic feed_zero_q, feed_zero_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic kill;

  // Output flags are decoded from the next state so they line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    k_reg_d     = k_reg_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          k_reg_d    = K_LEN;
          beat_cnt_d = '0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        flush_cnt_d = '0;
        state_d     = (k_reg_q != '0) ? STREAM : DONE_S;
      end
      STREAM: begin
        if (SRC_VALID) begin
          beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
          if (beat_cnt_q == k_reg_q - K_WIDTH'(1)) begin
            flush_cnt_d = '0;
            state_d     = (ARRAY_SIZE > 1) ? FLUSH : DONE_S;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = DONE_S;
        end
      end
      DONE_S: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (kill) begin
      state_d = IDLE;
    end

    ready_d     = (state_d == STREAM);
    clear_d     = (state_d == CLEAR);
    feed_zero_d = (state_d == FLUSH);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE_S);
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state_q     <= IDLE;
      k_reg_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      ready_q     <= 1'b0;
      clear_q     <= 1'b0;
      feed_zero_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_reg_q     <= k_reg_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ready_q     <= ready_d;
      clear_q     <= clear_d;
      feed_zero_q <= feed_zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Abort is honoured only in CLEAR/STREAM/FLUSH and clears the chains on that same cycle.
  assign kill        = ABORT & (clear_q | ready_q | feed_zero_q);
  assign SRC_READY   = ready_q;
  assign SR_EN       = clear_q | feed_zero_q | kill | (ready_q & SRC_VALID);
  assign SR_SYNC_RST = clear_q | kill;
  assign FEED_ZERO   = feed_zero_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

`ifdef STALL_COUNT_EN
  logic [K_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && START) begin
      stall_cnt_d = '0;
    end else if (state_q == STREAM && !SRC_VALID && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + K_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: doc/systolic_setup_controller.md
Name: systolic_setup_controller

Overview:
Sequences one operand-streaming pass through the skewing shift-register banks that feed the systolic array. Accepts a start command with a vector count. Clears the skew chains, then streams K_LEN vectors from an upstream valid/ready source. After that it feeds zeros until the skewed data has fully drained through the array, then signals completion. It sits between the tile scheduler and the shift-register/array enables.

Parameters:
ARRAY_SIZE, 4, systolic array dimension N (N >= 1); number of skew lanes
K_WIDTH, 16, width of the vector-count field

Ports:
CLK  input  1  clock, all logic on rising edge
ASYNC_RST  input  1  asynchronous reset, active-high
START  input  1  one-cycle command pulse; sampled only in IDLE
K_LEN  input  K_WIDTH  number of vectors to stream; captured with START
ABORT  input  1  terminate the current pass
SRC_VALID  input  1  upstream vector available
SRC_READY  output  1  controller accepts the vector this cycle
SR_EN  output  1  enable to all skew shift registers and the array
SR_SYNC_RST  output  1  synchronous clear to the skew shift registers
FEED_ZERO  output  1  selects zero instead of source data at the chain inputs
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle completion pulse

Behaviour:
- All outputs are 0 while ASYNC_RST is high. After release: state IDLE, counters 0.
- States: IDLE, CLEAR, STREAM, FLUSH, DONE_S.
- IDLE:
  - START=1 captures K_LEN into k_reg, clears beat_cnt, and moves to CLEAR.
  - START in any other state is ignored.
- CLEAR:
  - Lasts exactly 1 cycle, with SR_EN=1 and SR_SYNC_RST=1.
  - Goes to STREAM if k_reg != 0, otherwise to DONE_S (no flush).
- STREAM:
  - SRC_READY=1 and SR_EN=SRC_VALID; FEED_ZERO=0.
  - Each cycle with SRC_VALID=1 is a beat: beat_cnt increments.
  - When SRC_VALID=0, SR_EN=0 and the array stalls; there is no timeout.
  - The beat where beat_cnt == k_reg-1 goes to FLUSH (or to DONE_S if ARRAY_SIZE==1).
  - SRC_READY=0 in every state other than STREAM.
- FLUSH:
  - SR_EN=1 and FEED_ZERO=1 for exactly 2*ARRAY_SIZE-2 cycles (flush_cnt from 0 up to that count minus 1).
  - Then goes to DONE_S. FLUSH never stalls.
- DONE_S:
  - DONE=1 for 1 cycle; BUSY=1 in this cycle.
  - Next state is IDLE, so a new START is accepted one cycle after the DONE pulse.
- Latency with no stalls: START edge to DONE cycle = K_LEN + 2*ARRAY_SIZE cycles (1 CLEAR + K_LEN STREAM + 2N-2 FLUSH + 1).
- ABORT:
  - In CLEAR, STREAM or FLUSH, ABORT=1 moves to IDLE on the next edge.
  - On that abort cycle SR_EN=1 and SR_SYNC_RST=1, which clears the chains.
  - No DONE pulse is produced.
  - ABORT in IDLE or DONE_S is ignored.
  - ABORT and a final STREAM beat in the same cycle: ABORT wins.
- Counters are K_WIDTH bits. K_LEN=2^K_WIDTH-1 must complete without wrap.
- Async reset mid-pass: immediate return to IDLE with all outputs 0, and no DONE.

Optional Feature:
STALL_COUNT_EN
- Defined:
  - Adds output STALL_CNT (K_WIDTH bits).
  - Increments on each STREAM cycle with SRC_VALID=0 and saturates at all-ones.
  - Cleared when START is accepted; holds its value after DONE until the next START; 0 on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic pass: N=4, START with K_LEN=3, SRC_VALID tied 1 -> observed per cycle after START:
  - cycle 1: SR_SYNC_RST=1
  - cycles 2-4: SRC_READY=1
  - cycles 5-10: FEED_ZERO=1, SR_EN=1
  - cycle 11: DONE=1
  - cycle 12: BUSY=0
- Stall: K_LEN=3, SRC_VALID pattern 1,0,0,1,1 -> SR_EN low on the two gaps; DONE at cycle 13; STALL_CNT=2 when STALL_COUNT_EN is defined.
- Zero length: K_LEN=0 -> CLEAR, then DONE at cycle 2 after START, with no SRC_READY and no FEED_ZERO cycles.
- Abort: ABORT in the 2nd FLUSH cycle -> SR_SYNC_RST=1 and SR_EN=1 that cycle, IDLE next cycle, no DONE. A subsequent START runs normally.
- Ignored START: START pulsed during STREAM with K_LEN=9 -> the original pass with K_LEN=3 completes unchanged at cycle 11.
- Reset mid-STREAM: ASYNC_RST asserted for 2 cycles -> all outputs 0 immediately, BUSY=0, no DONE after release.
